// File: rtl/separable_allocator_iter.sv
// Separable switch allocator with selectable arbitration order.
// Requests are qualified by target range and output availability, then
// resolved by two stages of round-robin arbiters (input-first or
// output-first). Arbiter pointers move only on final grants, so an input
// that wins its first stage but then loses the second keeps its priority.
// Grants and crossbar selects are registered, one cycle after request.
module separable_allocator_iter #(
   parameter int PORT_NUM    = 5,
   parameter int VC_NUM      = 2,
   parameter int INPUT_FIRST = 1,
   localparam int OUT_W      = $clog2(PORT_NUM)
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0]            request_i,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0][OUT_W-1:0] out_port_i,
   input  logic [PORT_NUM-1:0]                        out_avail_i,
   output logic [PORT_NUM-1:0][VC_NUM-1:0]            grant_o,
   output logic [PORT_NUM-1:0][PORT_NUM-1:0]          xbar_sel_o
);

   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   // Port count widened by one bit so targets can be range-checked without
   // wrapping when PORT_NUM is not a power of two.
   localparam logic [OUT_W:0] PORT_LIM = (OUT_W+1)'(PORT_NUM);

   logic [PORT_NUM-1:0][VC_NUM-1:0]   q;
   logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_win;
   logic [PORT_NUM-1:0][VC_NUM-1:0]   elig;
   logic [PORT_NUM-1:0][VC_NUM-1:0]   grant_nxt;
   logic [PORT_NUM-1:0][PORT_NUM-1:0] port_req;   // [output][input]
   logic [PORT_NUM-1:0][PORT_NUM-1:0] out_win;    // [output][input]
   logic [PORT_NUM-1:0][PORT_NUM-1:0] xbar_nxt;   // [output][input]
   logic [PORT_NUM-1:0][VC_W-1:0]     in_ptr;
   logic [PORT_NUM-1:0][VC_W-1:0]     in_ptr_nxt;
   logic [PORT_NUM-1:0][OUT_W-1:0]    out_ptr;
   logic [PORT_NUM-1:0][OUT_W-1:0]    out_ptr_nxt;

   // Round robin over VCs: ptr has top priority, then ascending with wrap.
   function automatic logic [VC_NUM-1:0] rr_vc(input logic [VC_NUM-1:0] req,
                                               input logic [VC_W-1:0]   ptr);
      logic [VC_NUM-1:0] gnt;
      logic              found;
      int                idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < VC_NUM; k++) begin
         idx = (int'(ptr) + k) % VC_NUM;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

   // Round robin over input ports, same priority rule.
   function automatic logic [PORT_NUM-1:0] rr_port(input logic [PORT_NUM-1:0] req,
                                                   input logic [OUT_W-1:0]    ptr);
      logic [PORT_NUM-1:0] gnt;
      logic                found;
      int                  idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < PORT_NUM; k++) begin
         idx = (int'(ptr) + k) % PORT_NUM;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

   // Qualify each VC request: target in range and that output available.
   always_comb begin
      q = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
               if (request_i[i][v] && ({1'b0, out_port_i[i][v]} < PORT_LIM) &&
                   (out_port_i[i][v] == OUT_W'(o)) && out_avail_i[o]) begin
                  q[i][v] = 1'b1;
               end
            end
         end
      end
   end

   // Two-stage separable allocation in the configured order.
   always_comb begin
      vc_win    = '0;
      elig      = '0;
      port_req  = '0;
      out_win   = '0;
      grant_nxt = '0;
      xbar_nxt  = '0;
      if (INPUT_FIRST != 0) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            vc_win[i] = rr_vc(q[i], in_ptr[i]);
         end
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               for (int o = 0; o < PORT_NUM; o++) begin
                  if (vc_win[i][v] && (out_port_i[i][v] == OUT_W'(o))) begin
                     port_req[o][i] = 1'b1;
                  end
               end
            end
         end
         for (int o = 0; o < PORT_NUM; o++) begin
            out_win[o] = rr_port(port_req[o], out_ptr[o]);
         end
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               for (int o = 0; o < PORT_NUM; o++) begin
                  if (vc_win[i][v] && (out_port_i[i][v] == OUT_W'(o)) && out_win[o][i]) begin
                     grant_nxt[i][v] = 1'b1;
                     xbar_nxt[o][i]  = 1'b1;
                  end
               end
            end
         end
      end else begin
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               for (int o = 0; o < PORT_NUM; o++) begin
                  if (q[i][v] && (out_port_i[i][v] == OUT_W'(o))) begin
                     port_req[o][i] = 1'b1;
                  end
               end
            end
         end
         for (int o = 0; o < PORT_NUM; o++) begin
            out_win[o] = rr_port(port_req[o], out_ptr[o]);
         end
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               for (int o = 0; o < PORT_NUM; o++) begin
                  if (q[i][v] && (out_port_i[i][v] == OUT_W'(o)) && out_win[o][i]) begin
                     elig[i][v] = 1'b1;
                  end
               end
            end
         end
         for (int i = 0; i < PORT_NUM; i++) begin
            grant_nxt[i] = rr_vc(elig[i], in_ptr[i]);
         end
         // Outputs that picked an input whose VC arbiter chose elsewhere stay idle.
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               for (int o = 0; o < PORT_NUM; o++) begin
                  if (grant_nxt[i][v] && (out_port_i[i][v] == OUT_W'(o))) begin
                     xbar_nxt[o][i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Advance pointers past the final winner only; everything else holds.
   always_comb begin
      in_ptr_nxt  = in_ptr;
      out_ptr_nxt = out_ptr;
      for (int i = 0; i < PORT_NUM; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (grant_nxt[i][v]) begin
               in_ptr_nxt[i] = VC_W'((v + 1) % VC_NUM);
            end
         end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            if (xbar_nxt[o][i]) begin
               out_ptr_nxt[o] = OUT_W'((i + 1) % PORT_NUM);
            end
         end
      end
   end

   // Register grants, crossbar selects and arbiter pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_o    <= '0;
         xbar_sel_o <= '0;
         in_ptr     <= '0;
         out_ptr    <= '0;
      end else begin
         grant_o    <= grant_nxt;
         xbar_sel_o <= xbar_nxt;
         in_ptr     <= in_ptr_nxt;
         out_ptr    <= out_ptr_nxt;
      end
   end

endmodule
